tdm_mux: RTL

//   Parametrised N-channel, WIDTH-bit registered multiplexer with two modes.
//   - Manual: an external select picks the channel.
//   - Scan: an internal round-robin pointer visits enabled channels in turn.

---
 rtl/tdm_mux_pkg.sv | 17 +
 rtl/tdm_mux_rr_pick.sv | 37 +++
 rtl/tdm_mux.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/tdm_mux_pkg.sv
// Shared constants and helpers for the tdm_mux channel multiplexer.
package tdm_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Ceiling log2, clamped to 1 so a 2-channel build still has a 1-bit select.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tdm_mux_rr_pick.sv
// Round-robin picker: first enabled channel at or after ptr, wrapping past N-1.
module rr_pick
    import tdm_mux_pkg::*;
#(
    parameter  int N    = 8,
    localparam int SELW = clog2(N)
) (
    input  logic [N-1:0]    ch_en,
    input  logic [SELW-1:0] ptr,
    output logic            found,
    output logic [SELW-1:0] idx,
    output logic            wrapped
);

    logic [2*N-1:0]  dbl;
    logic [N-1:0]    rot;
    logic [SELW-1:0] off;
    logic [SELW:0]   sum;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
    always_comb begin
        dbl   = {ch_en, ch_en};
        rot   = N'(dbl >> ptr);
        found = 1'b0;
        off   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found = 1'b1;
                off   = SELW'(j);
            end
        end
        sum     = {1'b0, ptr} + {1'b0, off};
        wrapped = found && (sum >= (SELW + 1)'(N));
        idx     = wrapped ? SELW'(sum - (SELW + 1)'(N)) : SELW'(sum);
    end

endmodule

// File: rtl/tdm_mux.sv
// N-channel registered mux with manual select and round-robin scan over enabled channels.
// Define TDM_MUX_CHID_EN to add the out_ch port reporting the channel held in out_data.
module tdm_mux
    import tdm_mux_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int WIDTH = 8,
    localparam int SELW  = clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       ch_en,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err,
    output logic               scan_wrap
`ifdef TDM_MUX_CHID_EN
    ,
    output logic [SELW-1:0]    out_ch
`endif
);

    localparam int SELN = 1 << SELW;

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic             wrap_pend_q, wrap_pend_d;
    logic             sel_err_q, sel_err_d;
    logic             scan_wrap_q, scan_wrap_d;
`ifdef TDM_MUX_CHID_EN
    logic [SELW-1:0]  ch_q, ch_d;
`endif

    logic             load;
    logic [SELN-1:0]  en_pad;
    logic             sel_ok;
    logic             rr_found;
    logic [SELW-1:0]  rr_idx;
    logic             rr_wrapped;
    logic             pick_ok;
    logic [SELW-1:0]  pick_ch;
    logic [WIDTH-1:0] pick_data;

    rr_pick #(.N(N)) u_rr_pick (
        .ch_en   (ch_en),
        .ptr     (ptr_q),
        .found   (rr_found),
        .idx     (rr_idx),
        .wrapped (rr_wrapped)
    );

    assign load = !valid_q || out_ready;

    // Padding to a power of two makes any sel >= N read as a disabled channel.
    always_comb begin
        en_pad         = '0;
        en_pad[N-1:0]  = ch_en;
        sel_ok         = en_pad[sel];
    end

    // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        ptr_d       = ptr_q;
        wrap_pend_d = wrap_pend_q;
        sel_err_d   = 1'b0;
        scan_wrap_d = 1'b0;
        pick_ok     = 1'b0;
        pick_ch     = '0;
        pick_data   = '0;
`ifdef TDM_MUX_CHID_EN
        ch_d        = ch_q;
`endif
        if (load) begin
            if (mode == MODE_SCAN) begin
                pick_ok = rr_found;
                pick_ch = rr_idx;
                // Picking N-1 folds ptr to 0; the wrap is flagged on the next scanned
                // beat so scan_wrap always marks the first beat of a new round.
                if (rr_found) begin
                    ptr_d       = (int'(rr_idx) == N - 1) ? '0 : rr_idx + SELW'(1);
                    scan_wrap_d = rr_wrapped || wrap_pend_q;
                    wrap_pend_d = (int'(rr_idx) == N - 1);
                end
            end else begin
                pick_ok   = sel_ok;
                pick_ch   = sel;
                sel_err_d = !sel_ok;
            end
            for (int k = 0; k < N; k++) begin
                if (pick_ch == SELW'(k)) pick_data = in_data[k*WIDTH +: WIDTH];
            end
            valid_d = pick_ok;
            if (pick_ok) begin
                data_d = pick_data;
`ifdef TDM_MUX_CHID_EN
                ch_d   = pick_ch;
`endif
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            ptr_q       <= '0;
            wrap_pend_q <= 1'b0;
            sel_err_q   <= 1'b0;
            scan_wrap_q <= 1'b0;
`ifdef TDM_MUX_CHID_EN
            ch_q        <= '0;
`endif
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            ptr_q       <= ptr_d;
            wrap_pend_q <= wrap_pend_d;
            sel_err_q   <= sel_err_d;
            scan_wrap_q <= scan_wrap_d;
`ifdef TDM_MUX_CHID_EN
            ch_q        <= ch_d;
`endif
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign sel_err   = sel_err_q;
    assign scan_wrap = scan_wrap_q;
`ifdef TDM_MUX_CHID_EN
    assign out_ch    = ch_q;
`endif

endmodule
